// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq_unit.
//   opcode_e : operation select codes (3 bits, 7 legal codes + ILLEGAL)
//   state_e  : control FSM states
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_MUL     = 3'b010,
        OP_AND     = 3'b011,
        OP_OR      = 3'b100,
        OP_XOR     = 3'b101,
        OP_MAC     = 3'b110,
        OP_ILLEGAL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_unit_mul_shift_add.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst  : clock, async active-high reset
//   start     : load a, b, addend and begin a W-cycle multiply
//   a, b      : W-bit unsigned operands
//   addend    : W-bit term added in the final cycle (0 for plain MUL)
//   done      : high during the final busy cycle; product is valid after that edge
//   product   : 2W-bit result, (a*b + addend) mod 2^(2W), held until next start
module mul_shift_add #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   addend,
    output logic           done,
    output logic [2*W-1:0] product
);

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] step;
    logic [W-1:0]   mplier;
    logic [W-1:0]   addend_q;
    logic [W-1:0]   cnt;
    logic           busy;

    assign done    = busy && (cnt == W'(W - 1));
    assign product = acc;
    assign step    = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            addend_q <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            mcand    <= {{W{1'b0}}, a};
            mplier   <= b;
            addend_q <= addend;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            // Accumulate term folds into the last partial-product add, so MAC costs no extra cycle.
            acc    <= done ? step + {{W{1'b0}}, addend_q} : step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshakes on both sides.
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : request handshake; a, b, c, s captured on acceptance
//   a, b, c              : W-bit unsigned operands (c is the MAC accumulate term)
//   s                    : operation select (alu_seq_pkg::opcode_e)
//   out_valid / out_ready: result handshake
//   z                    : 2W-bit result
//   err                  : result came from the illegal select code
// Single-cycle ops go IDLE->DONE; MUL/MAC spend W cycles in CALC.
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    input  logic [2:0]     s,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] z,
    output logic           err
);

    state_e         state;
    opcode_e        op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] z_hold;
    logic           err_hold;
    logic [2*W-1:0] res;
    logic           res_err;
    logic [2*W-1:0] product;
    logic           mul_done;
    logic           accept;
    logic           is_mul;

    assign accept = in_valid && (state == ST_IDLE);
    assign is_mul = (s == OP_MUL) || (s == OP_MAC);

    mul_shift_add #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .addend  ((s == OP_MAC) ? c : '0),
        .done    (mul_done),
        .product (product)
    );

    // Single-cycle results from the registered operands; upper W bits of
    // logic ops are zero because the operands are zero-extended.
    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (op_q)
            OP_ADD:  res = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
            OP_SUB:  res = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
            OP_AND:  res = {{W{1'b0}}, a_q & b_q};
            OP_OR:   res = {{W{1'b0}}, a_q | b_q};
            OP_XOR:  res = {{W{1'b0}}, a_q ^ b_q};
            OP_MUL,
            OP_MAC:  res = product;
            default: res_err = 1'b1;
        endcase
    end

    // Outside DONE the outputs show the last presented result, so starting a
    // new request never disturbs z/err before its own result is ready.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign z         = (state == ST_DONE) ? res     : z_hold;
    assign err       = (state == ST_DONE) ? res_err : err_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            z_hold   <= '0;
            err_hold <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    op_q  <= opcode_e'(s);
                    a_q   <= a;
                    b_q   <= b;
                    state <= is_mul ? ST_CALC : ST_DONE;
                end
                ST_CALC: if (mul_done) state <= ST_DONE;
                ST_DONE: if (out_ready) begin
                    z_hold   <= res;
                    err_hold <= res_err;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0, b = '0, c = '0;
    logic [2:0]     s = '0;
    logic           in_ready, out_valid, err;
    logic [2*W-1:0] z;

    alu_seq_unit #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .s(s), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  s;
        logic [7:0]  a, b, c;
        logic [15:0] z;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] so, input logic [7:0] ao, input logic [7:0] bo,
                         input logic [7:0] co);
        @(negedge clk);
        chk("in_ready_before_req", in_ready, 1);
        s = so; a = ao; b = bo; c = co; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the acceptance edge as 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_hs", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
    endtask

    initial begin
        int lat;
        logic seen;
        vt[0]  = '{3'b000, 8'h01, 8'h02, 8'h03, 16'h0003, 1'b0, 1};
        vt[1]  = '{3'b001, 8'h01, 8'h02, 8'h03, 16'hFFFF, 1'b0, 1};
        vt[2]  = '{3'b011, 8'h01, 8'h02, 8'h03, 16'h0000, 1'b0, 1};
        vt[3]  = '{3'b100, 8'h01, 8'h02, 8'h03, 16'h0003, 1'b0, 1};
        vt[4]  = '{3'b101, 8'h01, 8'h02, 8'h03, 16'h0003, 1'b0, 1};
        vt[5]  = '{3'b010, 8'h01, 8'h02, 8'h03, 16'h0002, 1'b0, 9};
        vt[6]  = '{3'b110, 8'h01, 8'h02, 8'h03, 16'h0005, 1'b0, 9};
        vt[7]  = '{3'b010, 8'hFF, 8'hFF, 8'h03, 16'hFE01, 1'b0, 9};
        vt[8]  = '{3'b110, 8'hFF, 8'hFF, 8'hFF, 16'hFF00, 1'b0, 9};
        vt[9]  = '{3'b111, 8'h01, 8'h02, 8'h03, 16'h0000, 1'b1, 1};
        vt[10] = '{3'b000, 8'h01, 8'h02, 8'h03, 16'h0003, 1'b0, 1};
        vt[11] = '{3'b000, 8'hFF, 8'hFF, 8'h00, 16'h01FE, 1'b0, 1};

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z", z, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven sweep
        for (int i = 0; i < 12; i++) begin
            issue(vt[i].s, vt[i].a, vt[i].b, vt[i].c);
            wait_done(lat);
            chk($sformatf("vec%0d_z", i), z, vt[i].z);
            chk($sformatf("vec%0d_err", i), err, vt[i].e);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            handshake();
        end

        // Stall in DONE: outputs hold while inputs wiggle
        issue(3'b010, 8'h03, 8'h05, 8'h00);
        wait_done(lat);
        chk("hold_lat", lat, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = 8'(k * 37 + 11); b = 8'(k * 5 + 1); s = 3'(k);
            @(posedge clk); #1;
            chk("hold_z", z, 16'h000F);
            chk("hold_err", err, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        // Handshake edge with in_valid high must not accept
        @(negedge clk);
        s = 3'b000; a = 8'h01; b = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_no_accept_out_valid", out_valid, 0);
        chk("hs_no_accept_in_ready", in_ready, 1);
        chk("idle_z_held", z, 16'h000F);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_hs_accept_valid", out_valid, 1);
        chk("post_hs_accept_z", z, 16'h0003);
        handshake();

        // Reset during CALC cycle 4 aborts the multiply
        issue(3'b010, 8'hFF, 8'hFF, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_in_calc", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rst_in_ready", in_ready, 1);
        chk("abort_rst_z", z, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("abort_no_out_valid", seen, 0);
        issue(3'b000, 8'h01, 8'h02, 8'h03);
        wait_done(lat);
        chk("after_abort_z", z, 16'h0003);
        chk("after_abort_lat", lat, 1);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
